// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: D-deep feedback delay line,
// butterfly/select register, then a twiddle-multiplier register.
module sdf_r2_stage #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int NFFT         = 64,
  parameter int STAGE_NO     = 1,
  parameter int SCALE_EN     = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] in_r,
  input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] in_i,
  input  logic                                     inverse,
  output logic                                     out_valid,
  output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] out_r,
  output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0] out_i
);
  localparam int DW = INTEGER_SIZE + FRACT_SIZE;
  localparam int BW = DW + 1;
  localparam int PW = 2 * DW + 1;
  localparam int D  = NFFT >> STAGE_NO;
  localparam int NW = $clog2(2 * D);
  localparam int KW = $clog2(NFFT / 2);
  localparam logic signed [DW-1:0] MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};

  // Handshake: valid-only stream, no backpressure. A sample is consumed on every
  // rising edge with in_valid high; out_valid flags each cycle out_r/out_i hold a result.

  // Twiddle ROM: tw_cos = cos(2*pi*k/NFFT), tw_sin holds -sin(2*pi*k/NFFT).
  logic signed [DW-1:0] tw_cos [NFFT/2];
  logic signed [DW-1:0] tw_sin [NFFT/2];
  for (genvar g = 0; g < NFFT / 2; g++) begin : g_rom
    localparam real ANG   = 6.283185307179586 * real'(g) / real'(NFFT);
    localparam real ONE   = real'(longint'(1) << FRACT_SIZE);
    localparam int  COS_Q = $rtoi($floor($cos(ANG) * ONE + 0.5));
    localparam int  SIN_Q = $rtoi($floor(-$sin(ANG) * ONE + 0.5));
    assign tw_cos[g] = DW'(COS_Q);
    assign tw_sin[g] = DW'(SIN_Q);
  end

  function automatic logic signed [DW-1:0] bfly_post(input logic signed [BW-1:0] v);
    logic signed [BW-1:0] s;
    logic signed [DW-1:0] res;
    s = (SCALE_EN != 0) ? (v >>> 1) : v;
    if (s[BW-1] != s[BW-2]) res = s[BW-1] ? MIN_DW : MAX_DW;
    else                    res = s[DW-1:0];
    return res;
  endfunction

  function automatic logic signed [DW-1:0] prod_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    logic signed [DW-1:0] res;
    t = p >>> FRACT_SIZE;
    if (t > PW'(MAX_DW))      res = MAX_DW;
    else if (t < PW'(MIN_DW)) res = MIN_DW;
    else                      res = t[DW-1:0];
    return res;
  endfunction

  logic [NW-1:0]        n;
  logic                 primed;
  logic                 inv_lat;
  logic signed [DW-1:0] dl_r [D];
  logic signed [DW-1:0] dl_i [D];
  logic signed [DW-1:0] s1_r, s1_i;
  logic [KW-1:0]        s1_k;
  logic                 s1_inv;
  logic                 s1_valid;

  logic                 fill;
  logic [KW-1:0]        k_idx;
  logic signed [DW-1:0] sum_r, sum_i, dif_r, dif_i;

  // Fill phase is the lower half of the 2D-sample frame (top bit of n clear).
  always_comb begin
    fill  = ~n[NW-1];
    k_idx = KW'(n) << (STAGE_NO - 1);
    sum_r = bfly_post(BW'(dl_r[D-1]) + BW'(in_r));
    sum_i = bfly_post(BW'(dl_i[D-1]) + BW'(in_i));
    dif_r = bfly_post(BW'(dl_r[D-1]) - BW'(in_r));
    dif_i = bfly_post(BW'(dl_i[D-1]) - BW'(in_i));
  end

  logic signed [DW-1:0] tw_r, tw_i, mul_r, mul_i;

  always_comb begin
    tw_r  = tw_cos[s1_k];
    tw_i  = s1_inv ? -tw_sin[s1_k] : tw_sin[s1_k];
    mul_r = prod_sat(PW'(s1_r) * PW'(tw_r) - PW'(s1_i) * PW'(tw_i));
    mul_i = prod_sat(PW'(s1_r) * PW'(tw_i) + PW'(s1_i) * PW'(tw_r));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n         <= '0;
      primed    <= 1'b0;
      inv_lat   <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
      s1_r      <= '0;
      s1_i      <= '0;
      s1_k      <= '0;
      s1_inv    <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      // The sample at n == D is the first one with a real butterfly partner.
      s1_valid  <= in_valid & (primed | (n == NW'(D)));
      out_valid <= s1_valid;
      if (in_valid) begin
        n <= n + NW'(1);
        if (n == NW'(D)) primed  <= 1'b1;
        if (n == '0)     inv_lat <= inverse;
        s1_inv  <= (n == '0) ? inverse : inv_lat;
        dl_r[0] <= fill ? in_r : dif_r;
        dl_i[0] <= fill ? in_i : dif_i;
        for (int i = 1; i < D; i++) begin
          dl_r[i] <= dl_r[i-1];
          dl_i[i] <= dl_i[i-1];
        end
        if (fill) begin
          s1_r <= dl_r[D-1];
          s1_i <= dl_i[D-1];
          s1_k <= k_idx;
        end else begin
          s1_r <= sum_r;
          s1_i <= sum_i;
          s1_k <= '0;
        end
      end
      if (s1_valid) begin
        if (s1_k == '0) begin
          out_r <= s1_r;
          out_i <= s1_i;
        end else begin
          out_r <= mul_r;
          out_i <= mul_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: three instances (NFFT=8 unscaled, NFFT=8 scaled,
// NFFT=16 stage 2) driven in parallel and checked against a frame-level model.
module tb_sdf_r2_stage;
  localparam int  DW   = 18;
  localparam int  MAXV = 131071;
  localparam int  MINV = -131072;
  localparam int  ONEQ = 4096;
  localparam int  H    = 2896;
  localparam int  BIG  = 130662;
  localparam real ONE  = 4096.0;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [DW-1:0] in_r, in_i;
  logic inverse;
  logic ov0, ov1, ov2;
  logic signed [DW-1:0] or0, oi0, or1, oi1, or2, oi2;

  int n_cmp = 0;
  int n_bad = 0;
  int v0_cnt = 0;
  int stim_r[$];
  int stim_i[$];
  logic [2*DW-1:0] exp_q0[$];
  logic [2*DW-1:0] exp_q1[$];
  logic [2*DW-1:0] exp_q2[$];

  always #5 clk = ~clk;

  sdf_r2_stage #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(8), .STAGE_NO(1), .SCALE_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i), .inverse(inverse),
    .out_valid(ov0), .out_r(or0), .out_i(oi0));
  sdf_r2_stage #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(8), .STAGE_NO(1), .SCALE_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i), .inverse(inverse),
    .out_valid(ov1), .out_r(or1), .out_i(oi1));
  sdf_r2_stage #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(16), .STAGE_NO(2), .SCALE_EN(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i), .inverse(inverse),
    .out_valid(ov2), .out_r(or2), .out_i(oi2));

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint bfly(input longint v, input int scale);
    return sat(scale != 0 ? (v >>> 1) : v);
  endfunction

  function automatic void push_exp(input int idx, input logic [2*DW-1:0] v);
    case (idx)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic logic [2*DW-1:0] pop_exp(input int idx);
    case (idx)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Sample t of the stream is (frame t/2D, position n); for n>=D the stage emits
  // x[f][n-D]+x[f][n], for n<D of a later frame it emits (x[f-1][n]-x[f-1][n+D])*W^k.
  task automatic model_push(input int idx, input int nfft, input int stg, input int scale, input bit inv);
    int d, f, n, k;
    longint dr, di, tr, ti, vr, vi;
    real ang;
    d = nfft >> stg;
    for (int t = 0; t < stim_r.size(); t++) begin
      f = t / (2 * d);
      n = t % (2 * d);
      if (n >= d) begin
        vr = bfly(longint'(stim_r[t-d]) + stim_r[t], scale);
        vi = bfly(longint'(stim_i[t-d]) + stim_i[t], scale);
        push_exp(idx, {DW'(vr), DW'(vi)});
      end else if (f > 0) begin
        dr = bfly(longint'(stim_r[t-2*d]) - stim_r[t-d], scale);
        di = bfly(longint'(stim_i[t-2*d]) - stim_i[t-d], scale);
        k  = n * (1 << (stg - 1));
        if (k == 0) begin
          vr = dr;
          vi = di;
        end else begin
          ang = 6.283185307179586 * real'(k) / real'(nfft);
          tr  = longint'($rtoi($floor($cos(ang) * ONE + 0.5)));
          ti  = longint'($rtoi($floor(-$sin(ang) * ONE + 0.5)));
          if (inv) ti = -ti;
          vr = sat((dr * tr - di * ti) >>> 12);
          vi = sat((dr * ti + di * tr) >>> 12);
        end
        push_exp(idx, {DW'(vr), DW'(vi)});
      end
    end
  endtask

  task automatic check_dut(input int idx, input logic ov, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
    logic [2*DW-1:0] e;
    if (ov) begin
      n_cmp++;
      if (q_size(idx) == 0) begin
        n_bad++;
        $error("FAIL dut%0d_unexpected got %0d,%0d exp no output", idx, r, i);
      end else begin
        e = pop_exp(idx);
        assert ({r, i} === e) else begin
          n_bad++;
          $error("FAIL dut%0d_out got %0d,%0d exp %0d,%0d", idx, r, i, $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (ov0) v0_cnt++;
    check_dut(0, ov0, or0, oi0);
    check_dut(1, ov1, or1, oi1);
    check_dut(2, ov2, or2, oi2);
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {ov0, ov1, ov2}, 0);
    chk("rst_dut0_data", {or0, oi0}, 0);
    chk("rst_dut1_data", {or1, oi1}, 0);
    chk("rst_dut2_data", {or2, oi2}, 0);
    v0_cnt = 0;
    stim_r.delete();
    stim_i.delete();
    rst = 1'b1;
  endtask

  task automatic add(input int count, input int r, input int i);
    for (int c = 0; c < count; c++) begin
      stim_r.push_back(r);
      stim_i.push_back(i);
    end
  endtask

  task automatic push_const(input int count, input int r, input int i);
    for (int c = 0; c < count; c++) push_exp(0, {DW'(r), DW'(i)});
  endtask

  task automatic feed(input int gap_pct);
    for (int t = 0; t < stim_r.size(); t++) begin
      while ($urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_r = DW'(stim_r[t]);
      in_i = DW'(stim_i[t]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;
  endtask

  // Expectations for dut0 are pushed by the caller; dut1/dut2 come from the model.
  task automatic run(input string tag, input int gap_pct, input bit inv);
    inverse = inv;
    model_push(1, 8, 1, 1, inv);
    model_push(2, 16, 2, 0, inv);
    feed(gap_pct);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_left_q0"}, q_size(0), 0);
    chk({tag, "_left_q1"}, q_size(1), 0);
    chk({tag, "_left_q2"}, q_size(2), 0);
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(7, 0))
      0: return MAXV;
      1: return MINV;
      default: return int'($urandom_range(262143, 0)) - 131072;
    endcase
  endfunction

  initial begin
    inverse = 1'b0;
    // Constant 1.0 frame, then flush.
    do_reset();
    add(8, ONEQ, 0); add(4, 0, 0);
    push_const(4, 2 * ONEQ, 0); push_const(4, 0, 0);
    run("ones", 0, 1'b0);
    chk("ones_valid_cycles", v0_cnt, 8);

    // Impulse at n=0.
    do_reset();
    add(1, ONEQ, 0); add(11, 0, 0);
    push_const(1, ONEQ, 0); push_const(3, 0, 0);
    push_const(1, ONEQ, 0); push_const(3, 0, 0);
    run("impulse", 0, 1'b0);

    // Second half only: diffs are -W^k, forward then inverse.
    for (int pass = 0; pass < 3; pass++) begin
      bit inv;
      int sg;
      inv = (pass == 1);
      sg  = inv ? -1 : 1;
      do_reset();
      add(4, 0, 0); add(4, ONEQ, 0); add(4, 0, 0);
      push_const(4, ONEQ, 0);
      push_const(1, -ONEQ, 0);
      push_const(1, -H, sg * H);
      push_const(1, 0, sg * ONEQ);
      push_const(1, H, sg * H);
      run(pass == 2 ? "half_gaps" : "half", pass == 2 ? 40 : 0, inv);
      chk("half_valid_cycles", v0_cnt, 8);
    end

    // Near full-scale input: unscaled sums saturate.
    do_reset();
    add(8, BIG, BIG); add(4, 0, 0);
    push_const(4, MAXV, MAXV); push_const(4, 0, 0);
    run("satur", 0, 1'b0);

    // Reset mid-frame at n=5 of the third frame, then replay the 1.0 test.
    do_reset();
    add(21, ONEQ, 0);
    model_push(0, 8, 1, 0, 1'b0);
    run("pre_rst", 0, 1'b0);
    chk("pre_rst_valid_cycles", v0_cnt, 17);
    do_reset();
    add(8, ONEQ, 0); add(4, 0, 0);
    push_const(4, 2 * ONEQ, 0); push_const(4, 0, 0);
    run("replay", 0, 1'b0);
    chk("replay_valid_cycles", v0_cnt, 8);

    // Random multi-frame streams, back-to-back and with idle gaps.
    for (int r = 0; r < 4; r++) begin
      bit inv;
      inv = 1'($urandom_range(1, 0));
      do_reset();
      for (int t = 0; t < 28; t++) add(1, rnd_sample(), rnd_sample());
      model_push(0, 8, 1, 0, inv);
      run("random", (r < 2) ? 0 : 30, inv);
      chk("random_valid_cycles", v0_cnt, 24);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdf_r2_stage.md
SDF_R2_STAGE -- requirements
Module: sdf_r2_stage

Interface
REQ-001 SHALL have parameter INTEGER_SIZE, default 6, integer bits of the signed fixed-point sample.
REQ-002 SHALL have parameter FRACT_SIZE, default 12, fraction bits; DW = INTEGER_SIZE+FRACT_SIZE.
REQ-003 SHALL have parameter NFFT, default 64, power of two, 8..1024.
REQ-004 SHALL have parameter STAGE_NO, default 1, range 1..log2(NFFT); buffer depth D = NFFT>>STAGE_NO.
REQ-005 SHALL have parameter SCALE_EN, default 0; 1 = arithmetic right-shift by 1 of butterfly sum and difference.
REQ-006 SHALL have port clk, input, 1, the single clock; all flops rising-edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, the input sample is accepted this cycle.
REQ-009 SHALL have ports in_r/in_i, input, DW each, signed complex input sample.
REQ-010 SHALL have port inverse, input, 1, 1 = conjugate twiddles (IFFT); sampled only at frame start.
REQ-011 SHALL have port out_valid, output, 1, the output sample is valid this cycle.
REQ-012 SHALL have ports out_r/out_i, output, DW each, signed complex output sample.

Function
REQ-013 SHALL count accepted samples n modulo 2D; n and all pipeline and buffer state SHALL advance only on cycles where the corresponding valid is high. This is the stall behaviour.
REQ-014 Fill phase (n<D): the accepted input SHALL be written to the D-deep delay line. The delay-line output (a stored difference) SHALL be sent to the multiplier with twiddle index k = n*2^(STAGE_NO-1).
REQ-015 Butterfly phase (n>=D): with b = delay-line output and x = input, the stage SHALL emit sum b+x with the twiddle bypassed, and write difference b-x into the delay line.
REQ-016 Twiddle W^k SHALL be (cos(2*pi*k/NFFT), -sin(2*pi*k/NFFT)), stored as signed DW-bit values with FRACT_SIZE fraction bits in a ROM of NFFT/2 entries built at elaboration. Index 0 SHALL bypass the multiplier exactly.
REQ-017 When the latched inverse is 1, the imaginary part of each twiddle SHALL be negated.
REQ-018 inverse SHALL be latched on the accepted sample with n=0 and held for the whole 2D-sample frame.
REQ-019 Sum and difference SHALL be computed at DW+1 bits. The result SHALL then be shifted by 1 if SCALE_EN=1, then saturated to DW bits.
REQ-020 Complex products SHALL be full precision. Each product SHALL be truncated (floor) by FRACT_SIZE bits and saturated to DW bits.
REQ-021 Latency SHALL be exactly 2 valid-advancing pipeline steps: a butterfly/select register, then a multiplier register. With in_valid held high this is 2 cycles.
REQ-022 out_valid SHALL equal in_valid delayed through the same 2 steps, ANDed with primed.
REQ-023 primed SHALL set on the first accepted sample with n=D and stay set until reset. The first frame's fill-phase outputs (empty buffer) SHALL therefore never be flagged valid.
REQ-024 Output order per frame SHALL be D sums (natural k), followed during the next frame's fill phase by D twiddled differences. The user flushes the last frame by feeding D further samples (e.g. zeros).
REQ-025 n SHALL wrap from 2D-1 to 0 with no gap cycle. Back-to-back frames SHALL be supported at one sample per cycle.
REQ-026 Gaps in in_valid SHALL NOT alter any output value. They only stretch timing.

Reset
REQ-027 While rst=0: n=0, primed=0, delay line and all pipeline registers cleared, latched inverse=0, out_valid=0, out_r=out_i=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame. After release, the first accepted sample SHALL be treated as n=0 and priming SHALL restart.

Verification
REQ-029 Use NFFT=8, STAGE_NO=1, D=4, Q6.12. Feed 8 samples of 1.0+0j then 4 zeros. Required: 4 outputs 2.0+0j, then 4 outputs 0, with out_valid high for exactly 8 cycles.
REQ-030 Same config, impulse 1.0 at n=0 then zeros, 12 samples. Required: sums 1,0,0,0, then twiddled diffs 1, 0, 0, 0, since only k=0 is non-zero.
REQ-031 Same config, x[n]=1.0 for n>=4 only, then 4 zeros. Required: sums 1,1,1,1; diffs -W^0,-W^1,-W^2,-W^3, i.e. -1.0, (-0.7071,+0.7071), (0,+1.0), (+0.7071,+0.7071), within 1 LSB. With inverse=1, the imaginary signs of these diffs SHALL flip.
REQ-032 Repeat REQ-031 with random in_valid gaps (about 40% idle). Required: an identical valid-output sequence.
REQ-033 Inputs 31.9+31.9j at n<4 and n>=4, SCALE_EN=0. Required: sums saturate to 0x1FFFF in both real and imaginary. With SCALE_EN=1, sums are 31.9+31.9j with no saturation.
REQ-034 Assert rst at n=5 of frame 2, then release and replay REQ-029. Required: out_valid=0 and outputs 0 during reset, then results identical to REQ-029.
